// File: rtl/bsc_ompss_axis_tag_slice.sv
// bsc_ompss_axis_tag_slice
//   AXI-Stream register slice with a two-entry skid buffer. It drives a constant
//   TID on every beat, can force TDEST to a fixed value, and tracks packet
//   boundaries on the input side.
//   Optional feature macro: BSC_OMPSS_AXIS_TAG_SLICE_PKT_CNT_EN adds the
//   pkt_count output, which counts completed packets on the M side.
module bsc_ompss_axis_tag_slice #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    DEST_WIDTH = 2,
    parameter int                    ID_WIDTH   = 1,
    parameter logic [ID_WIDTH-1:0]   ID         = '0,
    parameter int                    DEST_MODE  = 0,
    parameter logic [DEST_WIDTH-1:0] DEST_VAL   = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic [DEST_WIDTH-1:0] S_AXIS_tdest,
    input  logic                  S_AXIS_tlast,
    input  logic                  S_AXIS_tvalid,
    output logic                  S_AXIS_tready,
    output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
    output logic [DEST_WIDTH-1:0] M_AXIS_tdest,
    output logic [ID_WIDTH-1:0]   M_AXIS_tid,
    output logic                  M_AXIS_tlast,
    output logic                  M_AXIS_tvalid,
    input  logic                  M_AXIS_tready,
`ifdef BSC_OMPSS_AXIS_TAG_SLICE_PKT_CNT_EN
    output logic [CNT_WIDTH-1:0]  pkt_count,
`endif
    output logic                  pkt_active
);

    // Occupancy of the slice: nothing held, main register only, main and skid.
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

    state_e                state_q, state_d;
    logic                  s_ready_q, s_ready_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [DEST_WIDTH-1:0] main_dest_q, main_dest_d;
    logic                  main_last_q, main_last_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [DEST_WIDTH-1:0] skid_dest_q, skid_dest_d;
    logic                  skid_last_q, skid_last_d;
    logic                  pkt_active_q, pkt_active_d;

    logic                  s_acc;
    logic                  m_acc;
    logic [DEST_WIDTH-1:0] in_dest;

    assign s_acc   = S_AXIS_tvalid & s_ready_q;
    assign m_acc   = m_valid_q & M_AXIS_tready;
    // The forced destination is applied on entry so both registers hold final values.
    assign in_dest = (DEST_MODE != 0) ? DEST_VAL : S_AXIS_tdest;

    // Next-state, register loads and packet tracking for the occupancy FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        s_ready_d    = s_ready_q;
        m_valid_d    = m_valid_q;
        main_data_d  = main_data_q;
        main_dest_d  = main_dest_q;
        main_last_d  = main_last_q;
        skid_data_d  = skid_data_q;
        skid_dest_d  = skid_dest_q;
        skid_last_d  = skid_last_q;
        pkt_active_d = pkt_active_q;

        case (state_q)
            ST_EMPTY: begin
                // Raises ready on the first edge after reset is released.
                s_ready_d = 1'b1;
                if (s_acc) begin
                    main_data_d = S_AXIS_tdata;
                    main_dest_d = in_dest;
                    main_last_d = S_AXIS_tlast;
                    m_valid_d   = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (s_acc && m_acc) begin
                    main_data_d = S_AXIS_tdata;
                    main_dest_d = in_dest;
                    main_last_d = S_AXIS_tlast;
                end else if (s_acc) begin
                    skid_data_d = S_AXIS_tdata;
                    skid_dest_d = in_dest;
                    skid_last_d = S_AXIS_tlast;
                    s_ready_d   = 1'b0;
                    state_d     = ST_FULL;
                end else if (m_acc) begin
                    m_valid_d   = 1'b0;
                    state_d     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (m_acc) begin
                    main_data_d = skid_data_q;
                    main_dest_d = skid_dest_q;
                    main_last_d = skid_last_q;
                    s_ready_d   = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                state_d   = ST_EMPTY;
                s_ready_d = 1'b0;
                m_valid_d = 1'b0;
            end
        endcase

        if (s_acc) begin
            pkt_active_d = ~S_AXIS_tlast;
        end
    end

    // Control state and the visible output payload, cleared by reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_EMPTY;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            main_data_q  <= '0;
            main_dest_q  <= '0;
            main_last_q  <= 1'b0;
            pkt_active_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            main_data_q  <= main_data_d;
            main_dest_q  <= main_dest_d;
            main_last_q  <= main_last_d;
            pkt_active_q <= pkt_active_d;
        end
    end

    // Skid payload storage; its contents are only meaningful in ST_FULL.
    always_ff @(posedge clk) begin
        // NOTE: the skid payload is not reset; the FSM state marks it invalid after reset.
        skid_data_q <= skid_data_d;
        skid_dest_q <= skid_dest_d;
        skid_last_q <= skid_last_d;
    end

`ifdef BSC_OMPSS_AXIS_TAG_SLICE_PKT_CNT_EN
    logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

    // Count packets completed on the M side; wraps naturally at the counter width.
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (m_acc && main_last_q) begin
            pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
        end
    end

    // Packet counter register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

    assign S_AXIS_tready = s_ready_q;
    assign M_AXIS_tvalid = m_valid_q;
    assign M_AXIS_tdata  = main_data_q;
    assign M_AXIS_tdest  = main_dest_q;
    assign M_AXIS_tlast  = main_last_q;
    assign M_AXIS_tid    = ID;
    assign pkt_active    = pkt_active_q;

endmodule

// File: tb/tb_bsc_ompss_axis_tag_slice.sv
// Testbench for bsc_ompss_axis_tag_slice. Two instances share the same stimulus:
// u_pass uses the default parameters (TDEST passthrough, ID=0), and u_force uses
// ID=1 with TDEST forced to 2 and a 2-bit packet counter.
// Both instances are checked against a queue-based model of the beats the slice holds.
module tb_bsc_ompss_axis_tag_slice;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [1:0]  s_tdest = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        m_tready = 1'b0;

    logic        s_ready1, m_valid1, m_last1, pkt_act1;
    logic [63:0] m_data1;
    logic [1:0]  m_dest1;
    logic [0:0]  m_tid1;
    logic        s_ready2, m_valid2, m_last2, pkt_act2;
    logic [63:0] m_data2;
    logic [1:0]  m_dest2;
    logic [0:0]  m_tid2;
`ifdef BSC_OMPSS_AXIS_TAG_SLICE_PKT_CNT_EN
    logic [15:0] cnt1;
    logic [1:0]  cnt2;
`endif

    always #5 clk = ~clk;

    bsc_ompss_axis_tag_slice u_pass (
        .clk(clk), .aresetn(aresetn),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tdest(s_tdest), .S_AXIS_tlast(s_tlast),
        .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_ready1),
        .M_AXIS_tdata(m_data1), .M_AXIS_tdest(m_dest1), .M_AXIS_tid(m_tid1),
        .M_AXIS_tlast(m_last1), .M_AXIS_tvalid(m_valid1), .M_AXIS_tready(m_tready),
`ifdef BSC_OMPSS_AXIS_TAG_SLICE_PKT_CNT_EN
        .pkt_count(cnt1),
`endif
        .pkt_active(pkt_act1)
    );

    bsc_ompss_axis_tag_slice #(
        .ID(1'b1), .DEST_MODE(1), .DEST_VAL(2'd2), .CNT_WIDTH(2)
    ) u_force (
        .clk(clk), .aresetn(aresetn),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tdest(s_tdest), .S_AXIS_tlast(s_tlast),
        .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_ready2),
        .M_AXIS_tdata(m_data2), .M_AXIS_tdest(m_dest2), .M_AXIS_tid(m_tid2),
        .M_AXIS_tlast(m_last2), .M_AXIS_tvalid(m_valid2), .M_AXIS_tready(m_tready),
`ifdef BSC_OMPSS_AXIS_TAG_SLICE_PKT_CNT_EN
        .pkt_count(cnt2),
`endif
        .pkt_active(pkt_act2)
    );

    // Reference model: the beats accepted but not yet delivered, in order.
    typedef struct {
        logic [63:0] data;
        logic [1:0]  dest;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic        model_pkt_active;
    int unsigned model_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("s_ready_pass",  s_ready1, exp_q.size() < 2);
        chk("s_ready_force", s_ready2, exp_q.size() < 2);
        chk("m_valid_pass",  m_valid1, exp_q.size() > 0);
        chk("m_valid_force", m_valid2, exp_q.size() > 0);
        chk("tid_pass",  m_tid1, 64'd0);
        chk("tid_force", m_tid2, 64'd1);
        chk("pkt_active_pass",  pkt_act1, model_pkt_active);
        chk("pkt_active_force", pkt_act2, model_pkt_active);
        if (exp_q.size() > 0) begin
            chk("data_pass",  m_data1, exp_q[0].data);
            chk("dest_pass",  m_dest1, exp_q[0].dest);
            chk("last_pass",  m_last1, exp_q[0].last);
            chk("data_force", m_data2, exp_q[0].data);
            chk("dest_force", m_dest2, 64'd2);
            chk("last_force", m_last2, exp_q[0].last);
        end
`ifdef BSC_OMPSS_AXIS_TAG_SLICE_PKT_CNT_EN
        chk("pkt_count_pass",  cnt1, model_cnt % 65536);
        chk("pkt_count_force", cnt2, model_cnt % 4);
`endif
    endtask

    // One clock cycle: check the outputs, drive new inputs, advance the model.
    task automatic step(input logic sv, input logic [63:0] d, input logic [1:0] dst,
                        input logic l, input logic mr);
        beat_t b;
        logic  s_acc, m_acc;
        @(negedge clk);
        check_outputs();
        s_tvalid = sv;
        s_tdata  = d;
        s_tdest  = dst;
        s_tlast  = l;
        m_tready = mr;
        s_acc = sv && (exp_q.size() < 2);
        m_acc = mr && (exp_q.size() > 0);
        if (m_acc) begin
            if (exp_q[0].last) model_cnt++;
            void'(exp_q.pop_front());
        end
        if (s_acc) begin
            b.data = d;
            b.dest = dst;
            b.last = l;
            exp_q.push_back(b);
            model_pkt_active = !l;
        end
    endtask

    // Asynchronous reset between clock edges, then release and check ready timing.
    task automatic do_reset();
        @(negedge clk);
        #2 aresetn = 1'b0;
        exp_q.delete();
        model_pkt_active = 1'b0;
        model_cnt = 0;
        #1;
        chk("rst_s_ready",  s_ready1 | s_ready2, 64'd0);
        chk("rst_m_valid",  m_valid1 | m_valid2, 64'd0);
        chk("rst_data",     m_data1 | m_data2, 64'd0);
        chk("rst_dest",     {m_dest1, m_dest2}, 64'd0);
        chk("rst_last",     m_last1 | m_last2, 64'd0);
        chk("rst_pkt_act",  pkt_act1 | pkt_act2, 64'd0);
        chk("rst_tid_pass", m_tid1, 64'd0);
        chk("rst_tid_force", m_tid2, 64'd1);
`ifdef BSC_OMPSS_AXIS_TAG_SLICE_PKT_CNT_EN
        chk("rst_pkt_count", {cnt1, cnt2}, 64'd0);
`endif
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        #1 chk("s_ready_before_edge", s_ready1, 64'd0);
        @(posedge clk);
        #1 chk("s_ready_after_edge", s_ready1, 64'd1);
    endtask

    initial begin
        model_pkt_active = 1'b0;
        model_cnt = 0;
        do_reset();

        // Streaming: 8 beats back to back with the sink always ready.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 64'(i), 2'(i), i == 7, 1'b1);
        end
        repeat (3) step(1'b0, '0, '0, 1'b0, 1'b1);

        // Backpressure: 3 beats offered into a stalled sink, then released.
        step(1'b1, 64'd100, 2'd1, 1'b0, 1'b0);
        step(1'b1, 64'd101, 2'd2, 1'b0, 1'b0);
        step(1'b1, 64'd102, 2'd3, 1'b1, 1'b0);
        step(1'b1, 64'd102, 2'd3, 1'b1, 1'b0);
        step(1'b1, 64'd102, 2'd3, 1'b1, 1'b1);
        step(1'b1, 64'd102, 2'd3, 1'b1, 1'b1);
        repeat (3) step(1'b0, '0, '0, 1'b0, 1'b1);

        // Packets: a 3-beat packet followed by a single-beat packet.
        step(1'b1, 64'hA0, 2'd1, 1'b0, 1'b1);
        step(1'b1, 64'hA1, 2'd1, 1'b0, 1'b1);
        step(1'b1, 64'hA2, 2'd1, 1'b1, 1'b1);
        step(1'b1, 64'hB0, 2'd1, 1'b1, 1'b1);
        repeat (2) step(1'b0, '0, '0, 1'b0, 1'b1);

        // Five more single-beat packets so the 2-bit counter wraps.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 64'hC0 + 64'(i), 2'd0, 1'b1, 1'b1);
        end
        repeat (2) step(1'b0, '0, '0, 1'b0, 1'b1);

        // Randomised traffic with random valid, ready and packet boundaries.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), {$urandom, $urandom}, 2'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
        end
        repeat (3) step(1'b0, '0, '0, 1'b0, 1'b1);

        // Reset while FULL and mid-packet, then a fresh beat must pass unchanged.
        step(1'b1, 64'hD0, 2'd1, 1'b0, 1'b0);
        step(1'b1, 64'hD1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 64'hD2, 2'd1, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 64'h5A5A_0F0F_1234_5678, 2'd3, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
